main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main_pkg.sv | 71 +++++++
 rtl/main_if.sv | 33 +++
 rtl/main_debounce.sv | 68 ++++++
 rtl/main.sv | 199 +++++++++++++++++++
 tb/tb_main.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_pkg.sv
// -----------------------------------------------------------------------------
// main_pkg
// Shared constants, types and helper functions for the keyboard/pattern
// sequencer block "main".
//   NOTE_W      width of the key/note bitmask (bit 0 = lowest pitch)
//   PAT_DEPTH   number of pattern memory entries
//   OFFSET_MAX  magnitude limit of the signed transpose offset
// Also holds the parameter defaults, the button index map and the
// transpose / offset helper functions.
// -----------------------------------------------------------------------------
package main_pkg;

    localparam int NOTE_W              = 27;
    localparam int PAT_DEPTH           = 16;
    localparam int PTR_W               = 4;
    localparam int LEN_W               = 5;
    localparam int OFFSET_MAX          = 4;
    localparam int OFF_W               = 4;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int STEP_CYCLES_DEF     = 1024;

    // Button positions inside the packed button vector
    localparam int BTN_SUSTAIN = 0;
    localparam int BTN_UP      = 1;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_REC     = 3;
    localparam int BTN_CLR     = 4;
    localparam int BTN_N       = 5;

    typedef logic [NOTE_W-1:0]        note_t;
    typedef logic signed [OFF_W-1:0]  offset_t;

    typedef enum logic {
        MODE_LIVE = 1'b0,
        MODE_PLAY = 1'b1
    } mode_e;

    localparam offset_t OFF_HI = offset_t'(OFFSET_MAX);
    localparam offset_t OFF_LO = offset_t'(-OFFSET_MAX);

    // Shift a note mask by a signed semitone offset; bits leaving the
    // 27-bit window are dropped and vacated positions are zero.
    function automatic note_t transpose(input note_t src, input offset_t off);
        offset_t mag;
        note_t   res;
        if (off[OFF_W-1]) begin
            mag = -off;
            res = src >> mag;
        end else begin
            res = src << off;
        end
        return res;
    endfunction

    // One up/down step of the offset, saturating at +/-OFFSET_MAX.
    // Both requests in the same cycle cancel out.
    function automatic offset_t offset_step(input offset_t cur,
                                            input logic    up,
                                            input logic    dn);
        offset_t res;
        res = cur;
        if (up && !dn && (cur < OFF_HI)) begin
            res = cur + offset_t'(1);
        end else if (dn && !up && (cur > OFF_LO)) begin
            res = cur - offset_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/main_if.sv
// -----------------------------------------------------------------------------
// main_if
// Signal bundle for the "main" block's user-facing I/O.
//   note           sounding-note bitmask produced by the block
//   key            raw key levels
//   b1..b5, sw1    raw push buttons and mode switch
// Modports:
//   master  the stimulus side (keyboard / panel): drives inputs, sees note
//   slave   the block side: receives inputs, drives note
// -----------------------------------------------------------------------------
interface main_if;
    import main_pkg::*;

    note_t note;
    note_t key;
    logic  b1;
    logic  b2;
    logic  b3;
    logic  b4;
    logic  b5;
    logic  sw1;

    modport master (
        output key, b1, b2, b3, b4, b5, sw1,
        input  note
    );

    modport slave (
        input  key, b1, b2, b3, b4, b5, sw1,
        output note
    );

endinterface

// File: rtl/main_debounce.sv
// -----------------------------------------------------------------------------
// main_debounce
// Two-flop synchronizer, counter debouncer and rising-edge pulse for one
// asynchronous push button.
// Ports:
//   clk      clock, all state on rising edge
//   reset    asynchronous active-low reset
//   i_btn    raw asynchronous button level
//   o_level  debounced level
//   o_rise   one-cycle pulse, high during the first cycle o_level is 1
// -----------------------------------------------------------------------------
module main_debounce
    import main_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_flip;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts the qualification window.
    assign w_differs = r_sync2 ^ r_level;
    assign w_flip    = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Registered alongside the level so the pulse lines up with the
            // first cycle of the new high level.
            r_rise  <= w_flip && r_sync2;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/main.sv
// -----------------------------------------------------------------------------
// main
// Keyboard note router with sustain, transpose and a 16-step pattern
// recorder/player.
// Ports:
//   note    registered bitmask of sounding notes, bit 0 = lowest pitch
//   key     asynchronous key levels
//   b1      sustain button          b2  transpose up
//   b3      transpose down          b4  record one step (live mode)
//   b5      clear pattern
//   sw1     mode switch: 0 live, 1 playback (synchronized, not debounced)
//   clk     sole clock
//   reset   asynchronous active-low reset
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a button level is accepted
//   STEP_CYCLES      clock cycles per playback step
// -----------------------------------------------------------------------------
module main
    import main_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STEP_CYCLES     = STEP_CYCLES_DEF
) (
    output logic [NOTE_W-1:0] note,
    input  logic [NOTE_W-1:0] key,
    input  logic              b1,
    input  logic              b2,
    input  logic              b3,
    input  logic              b4,
    input  logic              b5,
    input  logic              sw1,
    input  logic              clk,
    input  logic              reset
);

    localparam int               TMR_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);

    // Synchronizers for key and mode switch
    note_t r_key_s1;
    note_t r_key_s2;
    logic  r_sw_s1;
    logic  r_sw_s2;
    logic  r_sw_d;

    // Control state
    offset_t          r_offset;
    note_t            r_held;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LEN_W-1:0] r_len;
    logic [TMR_W-1:0] r_tmr;
    note_t            r_note;

    // Pattern storage, intentionally without reset: r_len masks stale data
    note_t r_mem [PAT_DEPTH];

    logic [BTN_N-1:0] w_btn_raw;
    logic [BTN_N-1:0] w_btn_lvl;
    logic [BTN_N-1:0] w_btn_rise;
    logic             w_unused;
    mode_e            w_mode;
    logic             w_sw_rise;
    logic             w_clear;
    logic             w_rec;
    logic [PTR_W-1:0] w_rd_next;
    note_t            w_src;

    assign w_btn_raw = {b5, b4, b3, b2, b1};

    genvar g;
    generate
        for (g = 0; g < BTN_N; g++) begin : g_btn
            main_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .i_btn   (w_btn_raw[g]),
                .o_level (w_btn_lvl[g]),
                .o_rise  (w_btn_rise[g])
            );
        end
    endgenerate

    // Only the sustain button acts on its level; the others act on edges.
    assign w_unused = ^{w_btn_lvl[BTN_N-1:1], w_btn_rise[BTN_SUSTAIN]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_sw_s1  <= 1'b0;
            r_sw_s2  <= 1'b0;
            r_sw_d   <= 1'b0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw1;
            r_sw_s2  <= r_sw_s1;
            r_sw_d   <= r_sw_s2;
        end
    end

    assign w_mode    = r_sw_s2 ? MODE_PLAY : MODE_LIVE;
    assign w_sw_rise = r_sw_s2 && !r_sw_d;

    // Clear beats a same-cycle record; recording is a live-mode action only.
    assign w_clear = w_btn_rise[BTN_CLR];
    assign w_rec   = w_btn_rise[BTN_REC] && (w_mode == MODE_LIVE) && !w_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_offset <= '0;
        end else begin
            r_offset <= offset_step(r_offset, w_btn_rise[BTN_UP], w_btn_rise[BTN_DOWN]);
        end
    end

    // Sustain accumulates while b1 is held in live mode; releasing b1 or
    // entering playback empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held <= '0;
        end else if ((w_mode == MODE_PLAY) || !w_btn_lvl[BTN_SUSTAIN]) begin
            r_held <= '0;
        end else begin
            r_held <= r_held | r_key_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
        end else if (w_rec) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_len != LEN_W'(PAT_DEPTH)) begin
                r_len <= r_len + 1'b1;
            end
        end
    end

    // Recorded steps are stored untransposed.
    always_ff @(posedge clk) begin
        if (w_rec) begin
            r_mem[r_wr_ptr] <= r_key_s2;
        end
    end

    // Wrap to step 0 after the last recorded step; a pattern cleared during
    // playback also lands back on 0 at the next step.
    always_comb begin
        w_rd_next = r_rd_ptr + 1'b1;
        if ((LEN_W'(r_rd_ptr) + LEN_W'(1)) >= r_len) begin
            w_rd_next = '0;
        end
    end

    // The step timer is parked at 0 in live mode and restarted when the
    // switch enters playback, so every playback run begins on step 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_tmr    <= '0;
        end else if (w_sw_rise || (w_mode == MODE_LIVE)) begin
            r_rd_ptr <= '0;
            r_tmr    <= '0;
        end else if (r_tmr == TMR_LAST) begin
            r_tmr    <= '0;
            r_rd_ptr <= w_rd_next;
        end else begin
            r_tmr    <= r_tmr + 1'b1;
        end
    end

    always_comb begin
        w_src = r_key_s2;
        if (w_mode == MODE_PLAY) begin
            w_src = (r_len == '0) ? '0 : r_mem[r_rd_ptr];
        end else if (w_btn_lvl[BTN_SUSTAIN]) begin
            w_src = r_held;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_note <= '0;
        end else begin
            r_note <= transpose(w_src, r_offset);
        end
    end

    assign note = r_note;

endmodule

// File: tb/tb_main.sv
module tb_main;
    import main_pkg::*;

    localparam int DEB  = 16;
    localparam int STEP = 8;

    localparam logic [4:0] P_SUS  = 5'b00001;
    localparam logic [4:0] P_UP   = 5'b00010;
    localparam logic [4:0] P_DN   = 5'b00100;
    localparam logic [4:0] P_REC  = 5'b01000;
    localparam logic [4:0] P_CLR  = 5'b10000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    main_if bus();

    main #(
        .DEBOUNCE_CYCLES (DEB),
        .STEP_CYCLES     (STEP)
    ) dut (
        .note  (bus.note),
        .key   (bus.key),
        .b1    (bus.b1),
        .b2    (bus.b2),
        .b3    (bus.b3),
        .b4    (bus.b4),
        .b5    (bus.b5),
        .sw1   (bus.sw1),
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected note value at an absolute cycle number
    int          exp_cyc [$];
    logic [26:0] exp_val [$];
    string       exp_tag [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    int          m_off = 0;
    logic [26:0] m_key = '0;
    logic [26:0] m_mem [16];
    int          m_wr  = 0;
    int          m_len = 0;

    function automatic logic [26:0] xp(input logic [26:0] m, input int off);
        if (off >= 0) return m << off;
        return m >> (-off);
    endfunction

    task automatic expect_at(input int c, input logic [26:0] v, input string tag);
        int i;
        i = 0;
        while (i < exp_cyc.size() && exp_cyc[i] <= c) i++;
        exp_cyc.insert(i, c);
        exp_val.insert(i, v);
        exp_tag.insert(i, tag);
    endtask

    task automatic chk(input logic [26:0] v, input string tag);
        expect_at(cyc + 1, v, tag);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_btns(input logic [4:0] w);
        bus.b1 = w[0];
        bus.b2 = w[1];
        bus.b3 = w[2];
        bus.b4 = w[3];
        bus.b5 = w[4];
    endtask

    task automatic press(input logic [4:0] w);
        drive_btns(w);
        tick(DEB + 8);
        drive_btns(5'b0);
        tick(DEB + 8);
    endtask

    // Live-mode key change: old value 2 cycles later, new value at 3 cycles
    task automatic set_key(input logic [26:0] k, input string tag);
        expect_at(cyc + 2, xp(m_key, m_off), tag);
        bus.key = k;
        m_key   = k;
        expect_at(cyc + 3, xp(m_key, m_off), tag);
        tick(6);
    endtask

    task automatic press_up();
        press(P_UP);
        if (m_off < 4) m_off++;
        chk(xp(m_key, m_off), "xpose_up");
    endtask

    task automatic press_dn();
        press(P_DN);
        if (m_off > -4) m_off--;
        chk(xp(m_key, m_off), "xpose_dn");
    endtask

    task automatic record_step();
        press(P_REC);
        m_mem[m_wr] = m_key;
        m_wr = (m_wr + 1) % 16;
        if (m_len < 16) m_len++;
    endtask

    // Monitor: compare note whenever a scheduled expectation comes due
    initial begin
        int          c;
        logic [26:0] v;
        string       t;
        forever begin
            @(negedge clk);
            while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
                c = exp_cyc.pop_front();
                v = exp_val.pop_front();
                t = exp_tag.pop_front();
                n_cmp++;
                if (c != cyc || bus.note !== v) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d (due %0d): note=%h required %h", t, cyc, c, bus.note, v);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        int          base;
        logic [26:0] r;

        bus.key = '0;
        bus.sw1 = 1'b0;
        drive_btns(5'b0);
        #1 reset = 1'b0;

        // Reset state
        tick(2);
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, 27'h0, "reset_state");
        tick(4);
        reset = 1'b1;
        tick(4);

        // Live latency: key 1 -> note 1 exactly 3 cycles later
        set_key(27'h1, "latency");
        for (int i = 0; i < 6; i++) set_key(27'($urandom), "live_rand");

        // Transpose and saturation
        set_key(27'h1, "xpose_key");
        for (int i = 0; i < 3; i++) press_up();
        chk(27'h8, "xpose_plus3");
        tick(2);
        for (int i = 0; i < 6; i++) press_up();
        chk(27'h10, "xpose_sat_hi");
        tick(2);
        for (int i = 0; i < 3; i++) press_dn();
        set_key(27'h4000000, "xpose_drop_top");
        press(P_UP | P_DN);
        chk(xp(m_key, m_off), "xpose_both");
        tick(2);
        set_key(27'h10, "xpose_key2");
        for (int i = 0; i < 7; i++) press_dn();
        chk(27'h1, "xpose_sat_lo");
        tick(2);
        set_key(27'h8, "xpose_drop_bot");
        for (int i = 0; i < 6; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: press_up();
                1: press_dn();
                2: begin
                    press(P_UP | P_DN);
                    chk(xp(m_key, m_off), "xpose_both_rand");
                end
                default: set_key(27'($urandom), "xpose_rand_key");
            endcase
            tick(2);
        end
        while (m_off > 0) press_dn();
        while (m_off < 0) press_up();

        // Sustain
        set_key(27'h0, "sus_pre");
        bus.b1 = 1'b1;
        tick(DEB + 8);
        chk(27'h0, "sus_empty");
        tick(2);
        bus.key = 27'h1;
        tick(8);
        bus.key = 27'h4;
        tick(8);
        bus.key = 27'h0;
        m_key   = 27'h0;
        tick(8);
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, 27'h5, "sus_hold");
        tick(6);
        bus.b1 = 1'b0;
        base   = cyc;
        expect_at(base + 10, 27'h5, "sus_release_wait");
        expect_at(base + DEB + 3, 27'h0, "sus_release");
        tick(DEB + 8);

        // Glitch on b1 shorter than the debounce window
        set_key(27'h2, "glitch_pre");
        bus.b1 = 1'b1;
        tick(4);
        set_key(27'h20, "glitch_track");
        bus.b1 = 1'b0;
        set_key(27'h0, "glitch_off");
        tick(30);
        chk(27'h0, "glitch_no_sustain");
        tick(2);

        // Record two steps and play them back
        set_key(27'h3, "rec_a");
        record_step();
        set_key(27'h10, "rec_b");
        record_step();
        set_key(27'h0, "rec_done");
        bus.sw1 = 1'b1;
        base = cyc;
        for (int k = 0; k < 6; k++)
            expect_at(base + 7 + STEP * k, xp(m_mem[k % m_len], m_off), "play_alt");
        tick(7 + STEP * 6 + 2);
        press(P_CLR);
        m_len = 0;
        m_wr  = 0;
        for (int i = 0; i < 3; i++) expect_at(cyc + 1 + 4 * i, 27'h0, "play_cleared");
        tick(12);
        bus.key = 27'h7;
        m_key   = 27'h7;
        press(P_REC);
        for (int i = 0; i < 3; i++) expect_at(cyc + 1 + 4 * i, 27'h0, "play_rec_ignored");
        tick(12);
        bus.sw1 = 1'b0;
        tick(6);
        chk(xp(m_key, m_off), "back_to_live");
        tick(2);

        // Longer random pattern that wraps the write pointer, with transpose
        press(P_CLR);
        m_len = 0;
        m_wr  = 0;
        press_up();
        tick(2);
        for (int i = 0; i < 18; i++) begin
            r = 27'($urandom);
            set_key(r, "rec_rand");
            record_step();
        end
        bus.sw1 = 1'b1;
        base = cyc;
        for (int k = 0; k < 20; k++)
            expect_at(base + 7 + STEP * k, xp(m_mem[k % m_len], m_off), "play_wrap");
        tick(7 + STEP * 20 + 2);

        // Reset during playback clears note at once and empties the pattern
        @(posedge clk);
        #2;
        expect_at(cyc, 27'h0, "reset_async");
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) expect_at(cyc + i, 27'h0, "reset_hold");
        tick(5);
        reset = 1'b1;
        m_off = 0;
        m_len = 0;
        m_wr  = 0;
        for (int k = 1; k <= 10; k++) expect_at(cyc + 3 * k, 27'h0, "reset_play_empty");
        tick(32);
        bus.sw1 = 1'b0;
        tick(6);
        chk(xp(m_key, m_off), "reset_offset_zero");
        tick(2);
        set_key(27'($urandom), "post_reset_live");

        for (int t = 0; t < 100 && exp_cyc.size() > 0; t++) @(negedge clk);
        if (exp_cyc.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations still pending, required 0", exp_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
